rw_recovery_arbiter: RTL and testbench
======================================

RW_RECOVERY_ARBITER -- requirements
Module: rw_recovery_arbiter

Interface
REQ-001 SHALL have parameter RW_LANE_NUM, default 2, the number of RW-stage lanes that can raise recovery requests.
REQ-002 SHALL have parameter AL_PTR_WIDTH, default 6, the ActiveList index width (ActiveListIndexPath).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port laneValid, input, RW_LANE_NUM bits: per-lane recovery request.
REQ-006 SHALL have port lanePtr, input, RW_LANE_NUM x AL_PTR_WIDTH: ActiveList index of the requesting op.
REQ-007 SHALL have port lanePC, input, RW_LANE_NUM x 32 (AddrPath): the recovered PC.
REQ-008 SHALL have port laneRefetchType, input, RW_LANE_NUM x RefetchType: the refetch type.
REQ-009 SHALL have port laneBrHistory, input, RW_LANE_NUM x BranchGlobalHistoryPath: the recovered branch history.
REQ-010 SHALL have port activeListHeadPtr, input, AL_PTR_WIDTH: the oldest in-flight op.
REQ-011 SHALL have port unableToStartRecovery, input, 1 bit: the recovery manager is busy.
REQ-012 SHALL have port exceptionDetectedInCommitStage, input, 1 bit: commit-stage recovery this cycle.
REQ-013 SHALL have port toCommitPhase, input, 1 bit: recovery is finishing.
REQ-014 SHALL have output exceptionDetectedInRwStage, 1 bit: a one-cycle issue pulse.
REQ-015 SHALL have outputs exceptionOpPtr (AL_PTR_WIDTH), recoveredPC_FromRwStage (32), refetchTypeFromRwStage (RefetchType) and recoveredBrHistoryFromRwStage, all valid while the pulse is high.
REQ-016 SHALL have output droppedReqCount, 16 bits: a saturating performance counter.

Function
REQ-017 SHALL compute age(p) as (p - activeListHeadPtr) mod 2^AL_PTR_WIDTH; a smaller age is older.
REQ-018 SHALL hold one pending request register: valid, ptr, pc, refetchType, brHistory.
REQ-019 SHALL select, each cycle, the oldest candidate among the pending register and the valid lanes.
REQ-020 SHALL resolve equal ages with pending first, then the lowest lane index.
REQ-021 SHALL drive exceptionDetectedInRwStage = pendingValid && !unableToStartRecovery && !exceptionDetectedInCommitStage && no incoming valid lane older than pending.
REQ-022 SHALL drive the issue payload outputs from the pending register only, giving a minimum latency of one cycle from laneValid to the pulse.
REQ-023 On an issue cycle, SHALL clear pending, set inflightValid=1 and set inflightPtr=pending.ptr.
REQ-024 On an issue cycle, SHALL discard incoming lanes that are younger than or equal to the issued op and count them as drops.
REQ-025 While not issuing, SHALL load pending with the selected oldest candidate.
REQ-026 SHALL count each valid lane that is not retained as a drop.
REQ-027 While inflightValid=1, SHALL accept an incoming lane only if age(lanePtr) < age(inflightPtr); otherwise it is dropped.
REQ-028 An accepted request SHALL wait in pending until unableToStartRecovery deasserts.
REQ-029 toCommitPhase=1 SHALL clear inflightValid at the next edge; a pending older request SHALL be retained.
REQ-030 exceptionDetectedInCommitStage=1 SHALL clear pending and inflightValid.
REQ-031 exceptionDetectedInCommitStage=1 SHALL drop that cycle's lane requests, with no pulse.
REQ-032 A simultaneous toCommitPhase and commit exception SHALL resolve as REQ-030 and REQ-031.
REQ-033 droppedReqCount SHALL add the popcount of dropped lanes per cycle, saturating at 0xFFFF.
REQ-034 SHALL handle pointer wrap-around only through the modular age of REQ-017; raw pointer compares are forbidden.
REQ-035 The state machine SHALL have states IDLE (no pending, no inflight), HOLD (pending, no inflight), INFLIGHT (inflight, no pending) and INFLIGHT_HOLD (both).
REQ-036 State SHALL be derived from {pendingValid, inflightValid} with transitions per REQ-021 through REQ-032.

Reset
REQ-037 On rst low, SHALL asynchronously clear pendingValid, inflightValid, droppedReqCount and all payload registers.
REQ-038 During and immediately after reset, exceptionDetectedInRwStage=0 and all outputs SHALL be 0.
REQ-039 Lane inputs SHALL be ignored while rst is low.
REQ-040 A reset asserted mid-recovery SHALL abandon the request with no pulse.

Structure
REQ-041 The RwRecoveryRequest struct {ptr, pc, refetchType, brHistory} SHALL live in RecoveryManagerTypes.
REQ-042 The RW_LANE_NUM default SHALL live in RecoveryManagerTypes.
REQ-043 RefetchType, AddrPath and BranchGlobalHistoryPath SHALL be reused from their existing packages.
REQ-044 SHALL contain one sub-module, al_age_oldest_select: a combinational oldest-of-N picker over ages with tie-break by index.

Verification
REQ-045 Bench SHALL cover: head=0, lane0 ptr=5 and lane1 ptr=3 in the same cycle, busy=0 -> next cycle pulse with exceptionOpPtr=3, drop count 1.
REQ-046 Bench SHALL cover: head=60, lane0 ptr=2 and lane1 ptr=62 -> ptr=62 issued (age 2 vs 6).
REQ-047 Bench SHALL cover: pending ptr=10, busy=1 for 4 cycles, then busy=0 -> exactly one pulse, in the first idle cycle.
REQ-048 Bench SHALL cover: inflight ptr=10 (head=0), lane ptr=12 -> dropped; lane ptr=7 -> held, then issued after busy drops.
REQ-049 Bench SHALL cover: pending ptr=4 with a commit exception the same cycle -> no pulse, pending cleared.
REQ-050 Bench SHALL cover: 70000 forced drops -> droppedReqCount=0xFFFF; async rst mid-cycle -> outputs 0 immediately.

Source files
------------

// File: rtl/rw_recovery_arbiter_pkg.sv
// Shared processor path types plus the RW-stage recovery arbiter's request record,
// lane-count default and arbiter state encoding.
package BasicTypes;
    localparam int ADDR_WIDTH = 32;
    typedef logic [ADDR_WIDTH-1:0] AddrPath;

    localparam int BRANCH_GLOBAL_HISTORY_WIDTH = 10;
    typedef logic [BRANCH_GLOBAL_HISTORY_WIDTH-1:0] BranchGlobalHistoryPath;

    typedef enum logic [1:0] {
        REFETCH_TYPE_THIS_PC       = 2'd0,
        REFETCH_TYPE_NEXT_PC       = 2'd1,
        REFETCH_TYPE_BRANCH_TARGET = 2'd2,
        REFETCH_TYPE_STORE_NEXT_PC = 2'd3
    } RefetchType;
endpackage

package RecoveryManagerTypes;
    import BasicTypes::*;

    localparam int RW_LANE_NUM_DEFAULT = 2;

    // Pointers are stored at a fixed maximum width so the record does not depend on
    // the arbiter's ActiveList width; instances narrow it back with a size cast.
    localparam int RW_PTR_MAX_WIDTH = 16;
    typedef logic [RW_PTR_MAX_WIDTH-1:0] RwPtrPath;

    typedef struct packed {
        RwPtrPath               ptr;
        AddrPath                pc;
        RefetchType             refetchType;
        BranchGlobalHistoryPath brHistory;
    } RwRecoveryRequest;

    // Encoding is {pendingValid, inflightValid}.
    typedef enum logic [1:0] {
        IDLE          = 2'b00,
        INFLIGHT      = 2'b01,
        HOLD          = 2'b10,
        INFLIGHT_HOLD = 2'b11
    } RwArbState;
endpackage

// File: rtl/rw_recovery_arbiter_select.sv
// Combinational oldest-of-N picker: smallest age wins, equal ages go to the lowest index.
module al_age_oldest_select #(
    parameter int NUM = 3,
    parameter int AGE_WIDTH = 6,
    localparam int IDX_WIDTH = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic [NUM-1:0]       candValid,
    input  logic [AGE_WIDTH-1:0] candAge [NUM],
    output logic                 found,
    output logic [IDX_WIDTH-1:0] oldestIdx
);
    logic [AGE_WIDTH-1:0] bestAge;

    always_comb begin
        found     = 1'b0;
        oldestIdx = '0;
        bestAge   = '0;
        for (int i = 0; i < NUM; i++) begin
            // Strict compare keeps the earlier (lower-index) candidate on a tie.
            if (candValid[i] && (!found || candAge[i] < bestAge)) begin
                found     = 1'b1;
                oldestIdx = IDX_WIDTH'(i);
                bestAge   = candAge[i];
            end
        end
    end
endmodule

// File: rtl/rw_recovery_arbiter.sv
// Arbitrates RW-stage recovery requests: keeps the oldest one pending, issues it as a
// one-cycle pulse when the recovery manager is free, and counts every dropped lane.
module rw_recovery_arbiter
    import BasicTypes::*;
    import RecoveryManagerTypes::*;
#(
    parameter int RW_LANE_NUM = RW_LANE_NUM_DEFAULT,
    parameter int AL_PTR_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RW_LANE_NUM-1:0]  laneValid,
    input  logic [AL_PTR_WIDTH-1:0] lanePtr [RW_LANE_NUM],
    input  AddrPath                 lanePC [RW_LANE_NUM],
    input  RefetchType              laneRefetchType [RW_LANE_NUM],
    input  BranchGlobalHistoryPath  laneBrHistory [RW_LANE_NUM],
    input  logic [AL_PTR_WIDTH-1:0] activeListHeadPtr,
    input  logic                    unableToStartRecovery,
    input  logic                    exceptionDetectedInCommitStage,
    input  logic                    toCommitPhase,
    output logic                    exceptionDetectedInRwStage,
    output logic [AL_PTR_WIDTH-1:0] exceptionOpPtr,
    output AddrPath                 recoveredPC_FromRwStage,
    output RefetchType              refetchTypeFromRwStage,
    output BranchGlobalHistoryPath  recoveredBrHistoryFromRwStage,
    output logic [15:0]             droppedReqCount
);
    localparam int CAND_NUM = RW_LANE_NUM + 1;
    localparam int IDX_WIDTH = (CAND_NUM > 1) ? $clog2(CAND_NUM) : 1;

    RwArbState               stateReg, stateNext;
    RwRecoveryRequest        pendingReg, pendingNext;
    logic [AL_PTR_WIDTH-1:0] inflightPtrReg, inflightPtrNext;
    logic [15:0]             droppedCountReg, droppedCountNext;

    logic pendingValid, inflightValid;
    assign pendingValid  = (stateReg == HOLD) || (stateReg == INFLIGHT_HOLD);
    assign inflightValid = (stateReg == INFLIGHT) || (stateReg == INFLIGHT_HOLD);

    // All ordering uses age relative to the ActiveList head, so wrap-around is free.
    logic [AL_PTR_WIDTH-1:0] pendingAge, inflightAge;
    assign pendingAge  = AL_PTR_WIDTH'(pendingReg.ptr) - activeListHeadPtr;
    assign inflightAge = inflightPtrReg - activeListHeadPtr;

    logic [AL_PTR_WIDTH-1:0] laneAge [RW_LANE_NUM];
    logic [RW_LANE_NUM-1:0]  laneEligible, laneOlderThanPending;
    RwRecoveryRequest        laneReq [RW_LANE_NUM];
    logic [CAND_NUM-1:0]     candValid;
    logic [AL_PTR_WIDTH-1:0] candAge [CAND_NUM];

    assign candValid[0] = pendingValid;
    assign candAge[0]   = pendingAge;

    generate
        for (genvar gi = 0; gi < RW_LANE_NUM; gi++) begin : g_lane
            assign laneAge[gi] = lanePtr[gi] - activeListHeadPtr;
            // A lane only survives if it is older than whatever recovery is already running.
            assign laneEligible[gi] = laneValid[gi] && !exceptionDetectedInCommitStage &&
                                      (!inflightValid || (laneAge[gi] < inflightAge));
            assign laneOlderThanPending[gi] = laneEligible[gi] && (laneAge[gi] < pendingAge);
            assign laneReq[gi] = '{
                ptr:         RwPtrPath'(lanePtr[gi]),
                pc:          lanePC[gi],
                refetchType: laneRefetchType[gi],
                brHistory:   laneBrHistory[gi]
            };
            assign candValid[gi + 1] = laneEligible[gi];
            assign candAge[gi + 1]   = laneAge[gi];
        end
    endgenerate

    logic                 selFound;
    logic [IDX_WIDTH-1:0] selIdx;

    al_age_oldest_select #(
        .NUM       (CAND_NUM),
        .AGE_WIDTH (AL_PTR_WIDTH)
    ) u_oldest (
        .candValid (candValid),
        .candAge   (candAge),
        .found     (selFound),
        .oldestIdx (selIdx)
    );

    logic issue;
    assign issue = pendingValid && !unableToStartRecovery &&
                   !exceptionDetectedInCommitStage && !(|laneOlderThanPending);

    logic                   pendingValidNext, inflightValidNext;
    logic [RW_LANE_NUM-1:0] retainMask, dropMask;
    logic [16:0]            dropSum;

    always_comb begin
        pendingValidNext  = pendingValid;
        inflightValidNext = inflightValid;
        pendingNext       = pendingReg;
        inflightPtrNext   = inflightPtrReg;
        retainMask        = '0;

        if (exceptionDetectedInCommitStage) begin
            pendingValidNext  = 1'b0;
            inflightValidNext = 1'b0;
        end else if (issue) begin
            // Every eligible lane here is no older than the issued op, so none is kept.
            pendingValidNext  = 1'b0;
            inflightValidNext = 1'b1;
            inflightPtrNext   = AL_PTR_WIDTH'(pendingReg.ptr);
        end else begin
            if (toCommitPhase) begin
                inflightValidNext = 1'b0;
            end
            if (selFound) begin
                pendingValidNext = 1'b1;
                for (int i = 0; i < RW_LANE_NUM; i++) begin
                    if (selIdx == IDX_WIDTH'(i + 1)) begin
                        pendingNext   = laneReq[i];
                        retainMask[i] = 1'b1;
                    end
                end
            end
        end

        stateNext = RwArbState'({pendingValidNext, inflightValidNext});
        dropMask  = laneValid & ~retainMask;

        dropSum = {1'b0, droppedCountReg};
        for (int i = 0; i < RW_LANE_NUM; i++) begin
            dropSum = dropSum + 17'(dropMask[i]);
        end
        droppedCountNext = dropSum[16] ? 16'hFFFF : dropSum[15:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pendingReg      <= '0;
            inflightPtrReg  <= '0;
            droppedCountReg <= '0;
        end else begin
            pendingReg      <= pendingNext;
            inflightPtrReg  <= inflightPtrNext;
            droppedCountReg <= droppedCountNext;
        end
    end

    assign exceptionDetectedInRwStage    = issue;
    assign exceptionOpPtr                = AL_PTR_WIDTH'(pendingReg.ptr);
    assign recoveredPC_FromRwStage       = pendingReg.pc;
    assign refetchTypeFromRwStage        = pendingReg.refetchType;
    assign recoveredBrHistoryFromRwStage = pendingReg.brHistory;
    assign droppedReqCount               = droppedCountReg;
endmodule

// File: tb/tb_rw_recovery_arbiter.sv
// Directed bench for rw_recovery_arbiter: age ordering, wrap, busy hold, inflight
// filtering, commit exceptions, drop-counter saturation and asynchronous reset.
module tb_rw_recovery_arbiter;
    import BasicTypes::*;
    import RecoveryManagerTypes::*;

    localparam int LANES = 2;
    localparam int W = 6;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [LANES-1:0]       laneValid;
    logic [W-1:0]           lanePtr [LANES];
    AddrPath                lanePC [LANES];
    RefetchType             laneRefetchType [LANES];
    BranchGlobalHistoryPath laneBrHistory [LANES];
    logic [W-1:0]           activeListHeadPtr;
    logic                   unableToStartRecovery;
    logic                   exceptionDetectedInCommitStage;
    logic                   toCommitPhase;
    logic                   exceptionDetectedInRwStage;
    logic [W-1:0]           exceptionOpPtr;
    AddrPath                recoveredPC_FromRwStage;
    RefetchType             refetchTypeFromRwStage;
    BranchGlobalHistoryPath recoveredBrHistoryFromRwStage;
    logic [15:0]            droppedReqCount;

    int checkCount = 0;
    int passCount = 0;
    int expDrops = 0;

    always #5 clk = ~clk;

    rw_recovery_arbiter #(
        .RW_LANE_NUM  (LANES),
        .AL_PTR_WIDTH (W)
    ) dut (
        .clk                            (clk),
        .rst                            (rst),
        .laneValid                      (laneValid),
        .lanePtr                        (lanePtr),
        .lanePC                         (lanePC),
        .laneRefetchType                (laneRefetchType),
        .laneBrHistory                  (laneBrHistory),
        .activeListHeadPtr              (activeListHeadPtr),
        .unableToStartRecovery          (unableToStartRecovery),
        .exceptionDetectedInCommitStage (exceptionDetectedInCommitStage),
        .toCommitPhase                  (toCommitPhase),
        .exceptionDetectedInRwStage     (exceptionDetectedInRwStage),
        .exceptionOpPtr                 (exceptionOpPtr),
        .recoveredPC_FromRwStage        (recoveredPC_FromRwStage),
        .refetchTypeFromRwStage         (refetchTypeFromRwStage),
        .recoveredBrHistoryFromRwStage  (recoveredBrHistoryFromRwStage),
        .droppedReqCount                (droppedReqCount)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setLane(input int idx, input logic [W-1:0] ptr, input AddrPath pc,
                           input RefetchType rt, input BranchGlobalHistoryPath hist);
        laneValid[idx]       = 1'b1;
        lanePtr[idx]         = ptr;
        lanePC[idx]          = pc;
        laneRefetchType[idx] = rt;
        laneBrHistory[idx]   = hist;
    endtask

    task automatic clearLanes();
        laneValid = '0;
        for (int i = 0; i < LANES; i++) begin
            lanePtr[i]         = '0;
            lanePC[i]          = '0;
            laneRefetchType[i] = REFETCH_TYPE_THIS_PC;
            laneBrHistory[i]   = '0;
        end
    endtask

    task automatic finishRecovery();
        toCommitPhase = 1'b1;
        tick();
        toCommitPhase = 1'b0;
    endtask

    task automatic test_reset();
        setLane(0, 6'd5, 32'h1111, REFETCH_TYPE_NEXT_PC, 10'h3FF);
        setLane(1, 6'd3, 32'h2222, REFETCH_TYPE_NEXT_PC, 10'h3FF);
        repeat (2) @(posedge clk);
        #1;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b0) $display("FAIL reset_pulse: got %0b want 0", exceptionDetectedInRwStage); else passCount++;
        checkCount++; if (exceptionOpPtr !== 6'd0) $display("FAIL reset_ptr: got %0d want 0", exceptionOpPtr); else passCount++;
        checkCount++; if (recoveredPC_FromRwStage !== 32'h0) $display("FAIL reset_pc: got %h want 0", recoveredPC_FromRwStage); else passCount++;
        checkCount++; if (droppedReqCount !== 16'd0) $display("FAIL reset_count: got %0d want 0", droppedReqCount); else passCount++;
        rst = 1'b1;
        clearLanes();
        tick();
        checkCount++; if (exceptionDetectedInRwStage !== 1'b0) $display("FAIL post_reset_pulse: got %0b want 0", exceptionDetectedInRwStage); else passCount++;
        checkCount++; if (droppedReqCount !== 16'd0) $display("FAIL post_reset_count: got %0d want 0", droppedReqCount); else passCount++;
        $display("test_reset done");
    endtask

    task automatic test_oldest();
        activeListHeadPtr = 6'd0;
        unableToStartRecovery = 1'b0;
        setLane(0, 6'd5, 32'h0000_0100, REFETCH_TYPE_NEXT_PC, 10'h011);
        setLane(1, 6'd3, 32'h0000_0200, REFETCH_TYPE_BRANCH_TARGET, 10'h022);
        #1;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b0) $display("FAIL oldest_no_same_cycle_pulse: got %0b want 0", exceptionDetectedInRwStage); else passCount++;
        tick();
        clearLanes();
        expDrops += 1;
        #1;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b1) $display("FAIL oldest_pulse: got %0b want 1", exceptionDetectedInRwStage); else passCount++;
        checkCount++; if (exceptionOpPtr !== 6'd3) $display("FAIL oldest_ptr: got %0d want 3", exceptionOpPtr); else passCount++;
        checkCount++; if (recoveredPC_FromRwStage !== 32'h0000_0200) $display("FAIL oldest_pc: got %h want 00000200", recoveredPC_FromRwStage); else passCount++;
        checkCount++; if (refetchTypeFromRwStage !== REFETCH_TYPE_BRANCH_TARGET) $display("FAIL oldest_refetch: got %0d want 2", refetchTypeFromRwStage); else passCount++;
        checkCount++; if (recoveredBrHistoryFromRwStage !== 10'h022) $display("FAIL oldest_hist: got %h want 022", recoveredBrHistoryFromRwStage); else passCount++;
        checkCount++; if (droppedReqCount !== 16'(expDrops)) $display("FAIL oldest_drops: got %0d want %0d", droppedReqCount, expDrops); else passCount++;
        tick();
        checkCount++; if (exceptionDetectedInRwStage !== 1'b0) $display("FAIL oldest_one_cycle: got %0b want 0", exceptionDetectedInRwStage); else passCount++;
        finishRecovery();
        $display("test_oldest done: ptr=%0d drops=%0d", exceptionOpPtr, droppedReqCount);
    endtask

    task automatic test_wrap();
        activeListHeadPtr = 6'd60;
        setLane(0, 6'd2, 32'h0000_0300, REFETCH_TYPE_THIS_PC, 10'h033);
        setLane(1, 6'd62, 32'h0000_0400, REFETCH_TYPE_NEXT_PC, 10'h044);
        tick();
        clearLanes();
        expDrops += 1;
        #1;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b1) $display("FAIL wrap_pulse: got %0b want 1", exceptionDetectedInRwStage); else passCount++;
        checkCount++; if (exceptionOpPtr !== 6'd62) $display("FAIL wrap_ptr: got %0d want 62", exceptionOpPtr); else passCount++;
        checkCount++; if (recoveredPC_FromRwStage !== 32'h0000_0400) $display("FAIL wrap_pc: got %h want 00000400", recoveredPC_FromRwStage); else passCount++;
        checkCount++; if (droppedReqCount !== 16'(expDrops)) $display("FAIL wrap_drops: got %0d want %0d", droppedReqCount, expDrops); else passCount++;
        tick();
        finishRecovery();
        activeListHeadPtr = 6'd0;
        $display("test_wrap done");
    endtask

    task automatic test_busy_hold();
        unableToStartRecovery = 1'b1;
        setLane(0, 6'd10, 32'h0000_0500, REFETCH_TYPE_THIS_PC, 10'h0AA);
        tick();
        clearLanes();
        for (int c = 0; c < 4; c++) begin
            #1;
            checkCount++; if (exceptionDetectedInRwStage !== 1'b0) $display("FAIL busy_hold_wait%0d: got %0b want 0", c, exceptionDetectedInRwStage); else passCount++;
            tick();
        end
        unableToStartRecovery = 1'b0;
        #1;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b1) $display("FAIL busy_release_pulse: got %0b want 1", exceptionDetectedInRwStage); else passCount++;
        checkCount++; if (exceptionOpPtr !== 6'd10) $display("FAIL busy_release_ptr: got %0d want 10", exceptionOpPtr); else passCount++;
        tick();
        checkCount++; if (exceptionDetectedInRwStage !== 1'b0) $display("FAIL busy_single_pulse: got %0b want 0", exceptionDetectedInRwStage); else passCount++;
        $display("test_busy_hold done (inflight ptr 10 left active)");
    endtask

    task automatic test_inflight_filter();
        setLane(0, 6'd12, 32'h0000_0600, REFETCH_TYPE_NEXT_PC, 10'h066);
        tick();
        clearLanes();
        expDrops += 1;
        #1;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b0) $display("FAIL inflight_younger_dropped: got %0b want 0", exceptionDetectedInRwStage); else passCount++;
        checkCount++; if (droppedReqCount !== 16'(expDrops)) $display("FAIL inflight_drop_count: got %0d want %0d", droppedReqCount, expDrops); else passCount++;
        unableToStartRecovery = 1'b1;
        setLane(0, 6'd7, 32'h0000_0700, REFETCH_TYPE_STORE_NEXT_PC, 10'h077);
        tick();
        clearLanes();
        #1;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b0) $display("FAIL inflight_older_held: got %0b want 0", exceptionDetectedInRwStage); else passCount++;
        unableToStartRecovery = 1'b0;
        #1;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b1) $display("FAIL inflight_older_pulse: got %0b want 1", exceptionDetectedInRwStage); else passCount++;
        checkCount++; if (exceptionOpPtr !== 6'd7) $display("FAIL inflight_older_ptr: got %0d want 7", exceptionOpPtr); else passCount++;
        checkCount++; if (recoveredPC_FromRwStage !== 32'h0000_0700) $display("FAIL inflight_older_pc: got %h want 00000700", recoveredPC_FromRwStage); else passCount++;
        checkCount++; if (droppedReqCount !== 16'(expDrops)) $display("FAIL inflight_keep_count: got %0d want %0d", droppedReqCount, expDrops); else passCount++;
        tick();
        finishRecovery();
        $display("test_inflight_filter done");
    endtask

    task automatic test_older_preempt();
        setLane(0, 6'd10, 32'h0000_0800, REFETCH_TYPE_THIS_PC, 10'h088);
        tick();
        clearLanes();
        setLane(1, 6'd6, 32'h0000_0900, REFETCH_TYPE_NEXT_PC, 10'h099);
        #1;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b0) $display("FAIL preempt_blocked: got %0b want 0", exceptionDetectedInRwStage); else passCount++;
        tick();
        clearLanes();
        #1;
        checkCount++; if (exceptionOpPtr !== 6'd6) $display("FAIL preempt_ptr: got %0d want 6", exceptionOpPtr); else passCount++;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b1) $display("FAIL preempt_pulse: got %0b want 1", exceptionDetectedInRwStage); else passCount++;
        checkCount++; if (droppedReqCount !== 16'(expDrops)) $display("FAIL preempt_drops: got %0d want %0d", droppedReqCount, expDrops); else passCount++;
        tick();
        finishRecovery();
        $display("test_older_preempt done");
    endtask

    task automatic test_tie();
        unableToStartRecovery = 1'b1;
        setLane(0, 6'd8, 32'h0000_0A00, REFETCH_TYPE_THIS_PC, 10'h0A0);
        tick();
        clearLanes();
        setLane(1, 6'd8, 32'h0000_0B00, REFETCH_TYPE_NEXT_PC, 10'h0B0);
        tick();
        clearLanes();
        expDrops += 1;
        unableToStartRecovery = 1'b0;
        #1;
        checkCount++; if (recoveredPC_FromRwStage !== 32'h0000_0A00) $display("FAIL tie_pending_first: got %h want 00000a00", recoveredPC_FromRwStage); else passCount++;
        checkCount++; if (droppedReqCount !== 16'(expDrops)) $display("FAIL tie_pending_drops: got %0d want %0d", droppedReqCount, expDrops); else passCount++;
        tick();
        finishRecovery();
        setLane(0, 6'd20, 32'h0000_0C00, REFETCH_TYPE_THIS_PC, 10'h0C0);
        setLane(1, 6'd20, 32'h0000_0D00, REFETCH_TYPE_NEXT_PC, 10'h0D0);
        tick();
        clearLanes();
        expDrops += 1;
        #1;
        checkCount++; if (recoveredPC_FromRwStage !== 32'h0000_0C00) $display("FAIL tie_low_lane: got %h want 00000c00", recoveredPC_FromRwStage); else passCount++;
        checkCount++; if (exceptionOpPtr !== 6'd20) $display("FAIL tie_low_lane_ptr: got %0d want 20", exceptionOpPtr); else passCount++;
        tick();
        finishRecovery();
        $display("test_tie done");
    endtask

    task automatic test_commit_exc();
        setLane(0, 6'd4, 32'h0000_0E00, REFETCH_TYPE_THIS_PC, 10'h0E0);
        tick();
        clearLanes();
        exceptionDetectedInCommitStage = 1'b1;
        setLane(1, 6'd9, 32'h0000_0F00, REFETCH_TYPE_THIS_PC, 10'h0F0);
        #1;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b0) $display("FAIL commit_blocks_pulse: got %0b want 0", exceptionDetectedInRwStage); else passCount++;
        tick();
        clearLanes();
        exceptionDetectedInCommitStage = 1'b0;
        expDrops += 1;
        #1;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b0) $display("FAIL commit_pending_cleared: got %0b want 0", exceptionDetectedInRwStage); else passCount++;
        checkCount++; if (droppedReqCount !== 16'(expDrops)) $display("FAIL commit_drop_count: got %0d want %0d", droppedReqCount, expDrops); else passCount++;
        exceptionDetectedInCommitStage = 1'b1;
        setLane(0, 6'd4, 32'h0000_1000, REFETCH_TYPE_THIS_PC, 10'h100);
        tick();
        clearLanes();
        exceptionDetectedInCommitStage = 1'b0;
        expDrops += 1;
        #1;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b0) $display("FAIL commit_lane_dropped: got %0b want 0", exceptionDetectedInRwStage); else passCount++;
        checkCount++; if (droppedReqCount !== 16'(expDrops)) $display("FAIL commit_lane_count: got %0d want %0d", droppedReqCount, expDrops); else passCount++;
        // Commit exception must also cancel an inflight recovery.
        setLane(0, 6'd10, 32'h0000_1100, REFETCH_TYPE_THIS_PC, 10'h110);
        tick();
        clearLanes();
        tick();
        exceptionDetectedInCommitStage = 1'b1;
        tick();
        exceptionDetectedInCommitStage = 1'b0;
        setLane(0, 6'd12, 32'h0000_1200, REFETCH_TYPE_NEXT_PC, 10'h120);
        tick();
        clearLanes();
        #1;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b1) $display("FAIL commit_clears_inflight: got %0b want 1", exceptionDetectedInRwStage); else passCount++;
        checkCount++; if (exceptionOpPtr !== 6'd12) $display("FAIL commit_clears_inflight_ptr: got %0d want 12", exceptionOpPtr); else passCount++;
        tick();
        finishRecovery();
        $display("test_commit_exc done");
    endtask

    task automatic test_tocommit_retain();
        setLane(0, 6'd10, 32'h0000_1400, REFETCH_TYPE_THIS_PC, 10'h140);
        tick();
        clearLanes();
        tick();
        unableToStartRecovery = 1'b1;
        setLane(0, 6'd5, 32'h0000_1500, REFETCH_TYPE_BRANCH_TARGET, 10'h150);
        tick();
        clearLanes();
        toCommitPhase = 1'b1;
        tick();
        toCommitPhase = 1'b0;
        unableToStartRecovery = 1'b0;
        #1;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b1) $display("FAIL tocommit_retain_pulse: got %0b want 1", exceptionDetectedInRwStage); else passCount++;
        checkCount++; if (exceptionOpPtr !== 6'd5) $display("FAIL tocommit_retain_ptr: got %0d want 5", exceptionOpPtr); else passCount++;
        tick();
        finishRecovery();
        $display("test_tocommit_retain done");
    endtask

    task automatic test_saturate();
        exceptionDetectedInCommitStage = 1'b1;
        setLane(0, 6'd1, 32'h0, REFETCH_TYPE_THIS_PC, 10'h0);
        setLane(1, 6'd2, 32'h0, REFETCH_TYPE_THIS_PC, 10'h0);
        repeat (35000) @(posedge clk);
        #1;
        exceptionDetectedInCommitStage = 1'b0;
        clearLanes();
        checkCount++; if (droppedReqCount !== 16'hFFFF) $display("FAIL saturate_count: got %h want ffff", droppedReqCount); else passCount++;
        tick();
        checkCount++; if (droppedReqCount !== 16'hFFFF) $display("FAIL saturate_hold: got %h want ffff", droppedReqCount); else passCount++;
        $display("test_saturate done: count=%h", droppedReqCount);
    endtask

    task automatic test_async_reset();
        setLane(0, 6'd9, 32'h0000_1900, REFETCH_TYPE_NEXT_PC, 10'h190);
        tick();
        clearLanes();
        #1;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b1) $display("FAIL areset_precondition: got %0b want 1", exceptionDetectedInRwStage); else passCount++;
        #1;
        rst = 1'b0;
        #1;
        checkCount++; if (exceptionDetectedInRwStage !== 1'b0) $display("FAIL areset_pulse: got %0b want 0", exceptionDetectedInRwStage); else passCount++;
        checkCount++; if (exceptionOpPtr !== 6'd0) $display("FAIL areset_ptr: got %0d want 0", exceptionOpPtr); else passCount++;
        checkCount++; if (recoveredPC_FromRwStage !== 32'h0) $display("FAIL areset_pc: got %h want 0", recoveredPC_FromRwStage); else passCount++;
        checkCount++; if (recoveredBrHistoryFromRwStage !== 10'h0) $display("FAIL areset_hist: got %h want 0", recoveredBrHistoryFromRwStage); else passCount++;
        checkCount++; if (droppedReqCount !== 16'd0) $display("FAIL areset_count: got %0d want 0", droppedReqCount); else passCount++;
        tick();
        rst = 1'b1;
        tick();
        checkCount++; if (exceptionDetectedInRwStage !== 1'b0) $display("FAIL areset_abandoned: got %0b want 0", exceptionDetectedInRwStage); else passCount++;
        $display("test_async_reset done");
    endtask

    initial begin
        clearLanes();
        activeListHeadPtr = '0;
        unableToStartRecovery = 1'b0;
        exceptionDetectedInCommitStage = 1'b0;
        toCommitPhase = 1'b0;
        test_reset();
        test_oldest();
        test_wrap();
        test_busy_hold();
        test_inflight_filter();
        test_older_preempt();
        test_tie();
        test_commit_exc();
        test_tocommit_retain();
        test_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
